// File: rtl/npu_port_pkg.sv
// Shared definitions for the NPU port queue.
// Holds the write-op priority encoding, the FIFO entry layout (flag bit on
// top of the data word) and the legal-range checks for the parameters.
package npu_port_pkg;

  // Write-side op after priority resolution: config wins over enqueue.
  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_CFG  = 2'd1,
    WR_ENQ  = 2'd2
  } wr_op_e;

  // FIFO entry = {is_cfg, word}; the flag sits above the data word.
  localparam int unsigned ENTRY_FLAG_W = 1;

  function automatic wr_op_e wr_op_decode(input logic cfg_op, input logic enq_op);
    wr_op_e op;
    op = WR_NONE;
    if (cfg_op)      op = WR_CFG;
    else if (enq_op) op = WR_ENQ;
    return op;
  endfunction

  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + ENTRY_FLAG_W;
  endfunction

  // Channel select width, never below one bit.
  function automatic int unsigned calc_ch_w(input int unsigned num_ch);
    int unsigned w;
    w = (num_ch <= 1) ? 1 : $clog2(num_ch);
    return w;
  endfunction

  function automatic bit num_ch_legal(input int unsigned num_ch);
    return (num_ch >= 1) && (num_ch <= 8);
  endfunction

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit deq_lat_legal(input int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

endpackage

// File: rtl/npu_port_queue_if.sv
// Execute-stage <-> NPU port bundle for npu_port_queue.
// slave : the queue (consumes execute ops and NPU status, drives NPU strobes).
// master: the surrounding pipeline / NPU model.
// Optional oStallCount exists only when NPU_PORT_STATS_EN is defined.
interface npu_port_queue_if
  import npu_port_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CH_W = calc_ch_w(NUM_CH);

  logic                     iCfgOp;
  logic                     iEnqOp;
  logic                     iDeqOp;
  logic [CH_W-1:0]          iChSel;
  logic [DATA_W-1:0]        iInstruction;
  logic [DATA_W-1:0]        iSrc;
  logic                     iStall;
  logic [NUM_CH-1:0]        iNpuFull;
  logic [NUM_CH-1:0]        iNpuEmpty;
  logic [NUM_CH*DATA_W-1:0] iNpuRdData;
  logic [NUM_CH*DATA_W-1:0] oNpuWrData;
  logic [NUM_CH-1:0]        oNpuCfgWe;
  logic [NUM_CH-1:0]        oNpuDataWe;
  logic [NUM_CH-1:0]        oNpuRe;
  logic [DATA_W-1:0]        oResult;
  logic                     oResultValid;
  logic                     oStallReq;
`ifdef NPU_PORT_STATS_EN
  logic [NUM_CH*16-1:0]     oStallCount;
`endif

  modport slave (
    input  iCfgOp, iEnqOp, iDeqOp, iChSel, iInstruction, iSrc, iStall,
    input  iNpuFull, iNpuEmpty, iNpuRdData,
    output oNpuWrData, oNpuCfgWe, oNpuDataWe, oNpuRe, oResult, oResultValid, oStallReq
`ifdef NPU_PORT_STATS_EN
    , output oStallCount
`endif
  );

  modport master (
    output iCfgOp, iEnqOp, iDeqOp, iChSel, iInstruction, iSrc, iStall,
    output iNpuFull, iNpuEmpty, iNpuRdData,
    input  oNpuWrData, oNpuCfgWe, oNpuDataWe, oNpuRe, oResult, oResultValid, oStallReq
`ifdef NPU_PORT_STATS_EN
    , input oStallCount
`endif
  );

endinterface

// File: rtl/npu_chan_fifo.sv
// Per-channel synchronous FIFO with full/empty/count.
// Ports: iClk, iRst_n (sync, active-low), push/push_data, pop, head (current
// front entry, combinational), full, empty, count.
// A push while full is ignored even if a pop happens in the same cycle.
module npu_chan_fifo #(
  parameter  int unsigned WIDTH = 33,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Status from the registered count, i.e. before this cycle's pop.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

  // Pointer, count and storage update; power-of-two depth makes wrap free.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/npu_port_queue.sv
// Execute-stage port to NUM_CH NPU channels.
// Buffers config/data writes per channel in one ordered FIFO each and drains
// them under NPU backpressure; issues dequeue reads and returns the data
// DEQ_LAT cycles later; raises oStallReq when an op cannot be taken.
// Ports: iClk, iRst_n (sync, active-low) and the npu_port_queue_if slave
// bundle (execute ops in, NPU strobes/data out, oResult/oResultValid,
// oStallReq). oNpuRe and oStallReq are combinational, the rest registered.
// Optional: define NPU_PORT_STATS_EN to add per-channel saturating 16-bit
// stall counters on oStallCount.
module npu_port_queue
  import npu_port_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEQ_LAT = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  npu_port_queue_if.slave  bus
);
  localparam int unsigned CH_W  = calc_ch_w(NUM_CH);
  localparam int unsigned ENT_W = entry_w(DATA_W);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  if (!num_ch_legal(NUM_CH) || !depth_legal(DEPTH) || !deq_lat_legal(DEQ_LAT)) begin : g_param_chk
    $error("npu_port_queue: illegal NUM_CH/DEPTH/DEQ_LAT");
  end

  wr_op_e                   wr_op;
  logic                     sel_ok;
  logic                     stall_req_c;
  logic                     wr_accept, deq_accept;
  logic [ENT_W-1:0]         push_entry;
  logic [NUM_CH-1:0]        sel_hit;
  logic [NUM_CH-1:0]        npu_re_c;
  logic [NUM_CH-1:0]        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]         fifo_head  [NUM_CH];
  logic [CNT_W-1:0]         fifo_count [NUM_CH];
  logic                     unused_count;

  logic [NUM_CH*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NUM_CH-1:0]        cfg_we_q, cfg_we_d;
  logic [NUM_CH-1:0]        data_we_q, data_we_d;
  logic [DEQ_LAT-1:0]       deq_vld_q, deq_vld_d;
  logic [CH_W-1:0]          deq_ch_q [DEQ_LAT];
  logic [CH_W-1:0]          deq_ch_d [DEQ_LAT];
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     result_vld_q, result_vld_d;

  // Op decode, stall request and acceptance; silent while in reset.
  always_comb begin
    wr_op       = wr_op_decode(bus.iCfgOp, bus.iEnqOp);
    sel_ok      = (32'(bus.iChSel) < NUM_CH);
    sel_hit     = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      sel_hit[ch] = sel_ok && (bus.iChSel == CH_W'(ch));
    end
    stall_req_c = iRst_n &&
                  (((wr_op != WR_NONE) && |(sel_hit & fifo_full)) ||
                   (bus.iDeqOp && |(sel_hit & bus.iNpuEmpty)));
    wr_accept   = iRst_n && !bus.iStall && !stall_req_c && (wr_op != WR_NONE) && sel_ok;
    deq_accept  = iRst_n && !bus.iStall && !stall_req_c && bus.iDeqOp && sel_ok;
    push_entry  = {(wr_op == WR_CFG), (wr_op == WR_CFG) ? bus.iInstruction : bus.iSrc};
    fifo_push   = wr_accept  ? sel_hit : '0;
    npu_re_c    = deq_accept ? sel_hit : '0;
    // Every channel drains independently whenever the NPU has room.
    fifo_pop    = ~fifo_empty & ~bus.iNpuFull;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    npu_chan_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .iClk      (iClk),
      .iRst_n    (iRst_n),
      .push      (fifo_push[g]),
      .push_data (push_entry),
      .pop       (fifo_pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .count     (fifo_count[g])
    );
  end

  // Occupancy is only needed inside the FIFOs; fold it so nothing dangles.
  always_comb begin
    unused_count = 1'b0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      unused_count = unused_count ^ (^fifo_count[ch]);
    end
  end

  // Drain strobes and the dequeue latency pipe.
  always_comb begin
    cfg_we_d  = '0;
    data_we_d = '0;
    wr_data_d = wr_data_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (fifo_pop[ch]) begin
        cfg_we_d[ch]                     = fifo_head[ch][ENT_W-1];
        data_we_d[ch]                    = !fifo_head[ch][ENT_W-1];
        wr_data_d[ch*DATA_W +: DATA_W]   = fifo_head[ch][DATA_W-1:0];
      end
    end

    deq_vld_d[0] = deq_accept;
    deq_ch_d[0]  = bus.iChSel;
    for (int unsigned i = 1; i < DEQ_LAT; i++) begin
      deq_vld_d[i] = deq_vld_q[i-1];
      deq_ch_d[i]  = deq_ch_q[i-1];
    end

    // Return data is valid while the entry sits in the last pipe stage.
    result_vld_d = deq_vld_q[DEQ_LAT-1];
    result_d     = result_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (deq_vld_q[DEQ_LAT-1] && (deq_ch_q[DEQ_LAT-1] == CH_W'(ch))) begin
        result_d = bus.iNpuRdData[ch*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wr_data_q    <= '0;
      cfg_we_q     <= '0;
      data_we_q    <= '0;
      deq_vld_q    <= '0;
      deq_ch_q     <= '{default: '0};
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      wr_data_q    <= wr_data_d;
      cfg_we_q     <= cfg_we_d;
      data_we_q    <= data_we_d;
      deq_vld_q    <= deq_vld_d;
      deq_ch_q     <= deq_ch_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
    end
  end

  assign bus.oNpuWrData   = wr_data_q;
  assign bus.oNpuCfgWe    = cfg_we_q;
  assign bus.oNpuDataWe   = data_we_q;
  assign bus.oNpuRe       = npu_re_c;
  assign bus.oResult      = result_q;
  assign bus.oResultValid = result_vld_q;
  assign bus.oStallReq    = stall_req_c;

`ifdef NPU_PORT_STATS_EN
  logic [NUM_CH*16-1:0] stall_cnt_q, stall_cnt_d;

  // Charge a stall cycle to the channel the blocked op targets; saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (stall_req_c && sel_hit[ch] && (stall_cnt_q[ch*16 +: 16] != 16'hFFFF)) begin
        stall_cnt_d[ch*16 +: 16] = stall_cnt_q[ch*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign bus.oStallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_npu_port_queue.sv
// Self-checking bench for npu_port_queue (NUM_CH=2, DEPTH=4, DEQ_LAT=2).
module tb_npu_port_queue;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DEQ_LAT = 2;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  npu_port_queue_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  npu_port_queue #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DEQ_LAT(DEQ_LAT)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_cfg;
    logic [31:0] word;
  } wr_exp_t;

  typedef struct {
    string      name;
    logic       cfg;
    logic       enq;
    logic       deq;
    int         ch;
    logic       stall;
    logic [1:0] empty;
    logic       exp_stall;
    logic [1:0] exp_re;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          strobe_cnt = 0;
  bit          mon_en = 1'b0;
  wr_exp_t     wr_q [NUM_CH][$];
  logic [31:0] res_q [$];
  logic [31:0] rd_val [NUM_CH] = '{32'h0000_BEEF, 32'h0000_CAFE};
  vec_t        vecs [8];
  wr_exp_t     mon_e;
  logic [31:0] mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clr_ops();
    bus.iCfgOp = 1'b0;
    bus.iEnqOp = 1'b0;
    bus.iDeqOp = 1'b0;
    bus.iStall = 1'b0;
  endtask

  // Present an op, wait (bounded) until it can be taken, record expectations.
  task automatic do_op(input logic cfg, input logic enq, input logic deq,
                       input int ch, input logic [31:0] word);
    int waited;
    waited = 0;
    @(negedge iClk);
    bus.iCfgOp = cfg;
    bus.iEnqOp = enq;
    bus.iDeqOp = deq;
    bus.iChSel = 1'(ch);
    bus.iInstruction = word;
    bus.iSrc = word;
    #1;
    while (bus.oStallReq) begin
      if (waited >= 30) begin
        chk("op_accept_timeout", 1, 0);
        clr_ops();
        return;
      end
      @(negedge iClk);
      #1;
      waited++;
    end
    @(posedge iClk);
    #1;
    if (cfg)      wr_q[ch].push_back({1'b1, word});
    else if (enq) wr_q[ch].push_back({1'b0, word});
    if (deq)      res_q.push_back(rd_val[ch]);
    clr_ops();
  endtask

  // Scoreboard: every NPU write strobe and every result is matched in order.
  always @(negedge iClk) begin
    if (mon_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (bus.oNpuCfgWe[ch] || bus.oNpuDataWe[ch]) begin
          strobe_cnt++;
          if (wr_q[ch].size() == 0) begin
            chk($sformatf("sb_unexpected_write_ch%0d", ch), 1, 0);
          end else begin
            mon_e = wr_q[ch].pop_front();
            chk($sformatf("sb_write_ch%0d", ch),
                {bus.oNpuCfgWe[ch], bus.oNpuDataWe[ch], bus.oNpuWrData[ch*32 +: 32]},
                {mon_e.is_cfg, !mon_e.is_cfg, mon_e.word});
          end
        end
      end
      if (bus.oResultValid) begin
        strobe_cnt++;
        if (res_q.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          mon_r = res_q.pop_front();
          chk("sb_result", bus.oResult, mon_r);
        end
      end
    end
  end

  initial begin
    int base;
    int left;
    vecs[0] = '{"idle",          0, 0, 0, 0, 0, 2'b00, 0, 2'b00};
    vecs[1] = '{"deq_ch0",       0, 0, 1, 0, 0, 2'b00, 0, 2'b01};
    vecs[2] = '{"deq_ch1_empty", 0, 0, 1, 1, 0, 2'b10, 1, 2'b00};
    vecs[3] = '{"deq_ch1",       0, 0, 1, 1, 0, 2'b01, 0, 2'b10};
    vecs[4] = '{"deq_ch0_istall",0, 0, 1, 0, 1, 2'b00, 0, 2'b00};
    vecs[5] = '{"cfg_deq_empty", 1, 0, 1, 1, 0, 2'b10, 1, 2'b00};
    vecs[6] = '{"enq_ch0",       0, 1, 0, 0, 0, 2'b00, 0, 2'b00};
    vecs[7] = '{"all_ops_ch0",   1, 1, 1, 0, 0, 2'b00, 0, 2'b01};

    clr_ops();
    bus.iChSel       = '0;
    bus.iInstruction = '0;
    bus.iSrc         = '0;
    bus.iNpuFull     = '0;
    bus.iNpuEmpty    = '0;
    bus.iNpuRdData   = {rd_val[1], rd_val[0]};

    // Reset state.
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk("rst_wrdata", bus.oNpuWrData, 0);
    chk("rst_we", {bus.oNpuCfgWe, bus.oNpuDataWe}, 0);
    chk("rst_result", {bus.oResultValid, bus.oResult}, 0);
    bus.iDeqOp = 1'b1; bus.iChSel = 1'b1; bus.iNpuEmpty = 2'b10;
    #1;
    chk("rst_stallreq", bus.oStallReq, 0);
    chk("rst_re", bus.oNpuRe, 0);
    clr_ops();
    bus.iNpuEmpty = 2'b00;
    @(negedge iClk);
    iRst_n = 1'b1;
    mon_en = 1'b1;

    // Combinational stall / read-strobe table, all FIFOs empty, no edge taken.
    foreach (vecs[i]) begin
      @(negedge iClk);
      bus.iCfgOp = vecs[i].cfg; bus.iEnqOp = vecs[i].enq; bus.iDeqOp = vecs[i].deq;
      bus.iChSel = 1'(vecs[i].ch); bus.iStall = vecs[i].stall; bus.iNpuEmpty = vecs[i].empty;
      #1;
      chk({vecs[i].name, "_stall"}, bus.oStallReq, vecs[i].exp_stall);
      chk({vecs[i].name, "_re"}, bus.oNpuRe, vecs[i].exp_re);
      clr_ops();
      bus.iNpuEmpty = 2'b00;
    end

    // Single enqueue on ch1: strobe exactly one cycle, one edge after accept.
    do_op(0, 1, 0, 1, 32'hA5A5_0001);
    @(negedge iClk);
    chk("enq_lat_early", {bus.oNpuCfgWe, bus.oNpuDataWe}, 0);
    @(negedge iClk);
    chk("enq_lat_we", {bus.oNpuCfgWe, bus.oNpuDataWe}, {2'b00, 2'b10});
    chk("enq_lat_data", bus.oNpuWrData[63:32], 32'hA5A5_0001);
    @(negedge iClk);
    chk("enq_lat_once", {bus.oNpuCfgWe, bus.oNpuDataWe}, 0);

    // Config then data held behind NPU backpressure keep their order.
    bus.iNpuFull = 2'b01;
    do_op(1, 0, 0, 0, 32'h1111);
    do_op(0, 1, 0, 0, 32'h2222);
    repeat (5) @(negedge iClk);
    chk("held_no_we", {bus.oNpuCfgWe, bus.oNpuDataWe}, 0);
    bus.iNpuFull = 2'b00;
    @(negedge iClk);
    chk("order_cfg", {bus.oNpuCfgWe, bus.oNpuDataWe, bus.oNpuWrData[31:0]},
        {2'b01, 2'b00, 32'h1111});
    @(negedge iClk);
    chk("order_data", {bus.oNpuCfgWe, bus.oNpuDataWe, bus.oNpuWrData[31:0]},
        {2'b00, 2'b01, 32'h2222});

    // Fill ch0 to DEPTH; the next push stalls until a pop has happened.
    bus.iNpuFull = 2'b01;
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 0, 0, 32'h100 + i);
    @(negedge iClk);
    bus.iEnqOp = 1'b1; bus.iChSel = 1'b0; bus.iSrc = 32'h105;
    #1;
    chk("full_stall", bus.oStallReq, 1);
    @(negedge iClk);
    #1;
    chk("full_stall_hold", bus.oStallReq, 1);
    bus.iNpuFull = 2'b00;
    #1;
    chk("full_stall_pop_cycle", bus.oStallReq, 1);
    @(posedge iClk);
    #1;
    chk("full_stall_after_pop", bus.oStallReq, 0);
    @(posedge iClk);
    #1;
    wr_q[0].push_back({1'b0, 32'h105});
    clr_ops();

    // Back-to-back dequeues return back-to-back results in issue order.
    @(negedge iClk);
    bus.iDeqOp = 1'b1; bus.iChSel = 1'b0;
    #1;
    chk("deq_re_ch0", bus.oNpuRe, 2'b01);
    @(posedge iClk);
    #1;
    res_q.push_back(rd_val[0]);
    bus.iChSel = 1'b1;
    #1;
    chk("deq_re_ch1", bus.oNpuRe, 2'b10);
    @(posedge iClk);
    #1;
    res_q.push_back(rd_val[1]);
    clr_ops();
    @(negedge iClk);
    chk("deq_res_early", bus.oResultValid, 0);
    @(negedge iClk);
    chk("deq_res_first", {bus.oResultValid, bus.oResult}, {1'b1, 32'h0000_BEEF});
    @(negedge iClk);
    chk("deq_res_second", {bus.oResultValid, bus.oResult}, {1'b1, 32'h0000_CAFE});
    @(negedge iClk);
    chk("deq_res_end", bus.oResultValid, 0);

    // Dequeue from an empty NPU channel stalls, then reads exactly once.
    @(negedge iClk);
    bus.iNpuEmpty = 2'b10; bus.iDeqOp = 1'b1; bus.iChSel = 1'b1;
    #1;
    chk("deq_empty_stall", bus.oStallReq, 1);
    chk("deq_empty_re", bus.oNpuRe, 0);
    @(negedge iClk);
    bus.iNpuEmpty = 2'b00;
    #1;
    chk("deq_ready_re", bus.oNpuRe, 2'b10);
    @(posedge iClk);
    #1;
    res_q.push_back(rd_val[1]);
    clr_ops();
    @(negedge iClk);
    #1;
    chk("deq_ready_once", bus.oNpuRe, 0);
    repeat (4) @(negedge iClk);

    // Reset with entries queued and a dequeue in flight discards everything.
    bus.iNpuFull = 2'b01;
    for (int i = 0; i < 3; i++) do_op(0, 1, 0, 0, 32'hD0 + i);
    do_op(0, 0, 1, 1, 32'h0);
    iRst_n = 1'b0;
    wr_q[0].delete();
    wr_q[1].delete();
    res_q.delete();
    base = strobe_cnt;
    repeat (3) @(negedge iClk);
    iRst_n = 1'b1;
    bus.iNpuFull = 2'b00;
    repeat (10) @(negedge iClk);
    chk("post_reset_strobes", strobe_cnt - base, 0);
    do_op(0, 1, 0, 0, 32'h77);

    // Let the scoreboard empty out, bounded.
    left = 1;
    for (int w = 0; w < 50 && left != 0; w++) begin
      @(negedge iClk);
      left = wr_q[0].size() + wr_q[1].size() + res_q.size();
    end
    chk("scoreboard_drained", left, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/npu_port_queue.md
Name: npu_port_queue

Overview:
- Parametrised successor to the execution-stage NPU port logic; sits between the execute stage and NUM_CH NPU channels.
- Buffers config-word and data enqueues per channel in ordered FIFOs and drains them under NPU backpressure.
- Issues dequeue reads and realigns returned data after a configurable latency.
- Requests a pipeline stall when an operation cannot be accepted.

Parameters:
- NUM_CH, 2, number of NPU channels (1..8)
- DATA_W, 32, width of config/data words
- DEPTH, 4, entries per channel FIFO (power of two, >=2)
- DEQ_LAT, 1, cycles from oNpuRe pulse to valid iNpuRdData (1..4)
- CH_W, derived localparam: max(1, clog2(NUM_CH))

Ports:
- iClk  in  1  clock
- iRst_n  in  1  synchronous, active-low reset
- iCfgOp  in  1  config-write op in execute
- iEnqOp  in  1  data-enqueue op in execute
- iDeqOp  in  1  dequeue op in execute
- iChSel  in  CH_W  target channel
- iInstruction  in  DATA_W  config word (used when iCfgOp)
- iSrc  in  DATA_W  forwarded operand (used when iEnqOp)
- iStall  in  1  pipeline stall from hazard unit
- iNpuFull  in  NUM_CH  per-channel NPU input FIFO full
- iNpuEmpty  in  NUM_CH  per-channel NPU output FIFO empty
- iNpuRdData  in  NUM_CH*DATA_W  per-channel return data
- oNpuWrData  out  NUM_CH*DATA_W  per-channel write word
- oNpuCfgWe  out  NUM_CH  config write strobe
- oNpuDataWe  out  NUM_CH  data write strobe
- oNpuRe  out  NUM_CH  dequeue read strobe
- oResult  out  DATA_W  dequeued word, to writeback
- oResultValid  out  1  oResult qualifier
- oStallReq  out  1  request pipeline stall

Behaviour:
- Reset: all FIFOs emptied, latency pipe cleared; oNpuWrData=0, oNpuCfgWe=0, oNpuDataWe=0, oResult=0, oResultValid=0. oNpuRe=0 and oStallReq=0 while iRst_n=0.
- Reset mid-operation discards queued entries and in-flight dequeues; no strobe fires after reset asserts.
- Op priority: iCfgOp > iEnqOp. Both high together: enqueue is dropped. iDeqOp is independent and may coincide with either.
- Accept condition: op && !iStall && !oStallReq.
- Accepted cfg/enq pushes {isCfg, word} into FIFO[iChSel]. A single FIFO per channel keeps config/data order.
- oStallReq is combinational:
  - (iCfgOp|iEnqOp) && FIFO[iChSel] full, OR
  - iDeqOp && iNpuEmpty[iChSel].
- Drain: each cycle, every channel with a non-empty FIFO and iNpuFull[ch]=0 pops its head.
  - Next cycle, the registered oNpuCfgWe[ch] or oNpuDataWe[ch] is high for 1 cycle, with oNpuWrData slice = word. Otherwise strobes are 0 and data holds.
  - Minimum latency: push at edge k, strobe high in the cycle after edge k+1.
- Full FIFO with simultaneous pop: pop proceeds. The push is still stalled because fullness is evaluated before the pop.
- Count rule: count += push − pop. Pointers wrap modulo DEPTH.
- Dequeue:
  - Accepted dequeue drives oNpuRe[iChSel]=1 combinationally for that cycle and enters {1, ch} into a DEQ_LAT-deep shift pipe.
  - On pipe exit, oResult <= iNpuRdData[ch] registered and oResultValid=1 for 1 cycle.
  - Back-to-back dequeues yield back-to-back results in issue order.
- iStall freezes acceptance only. Drain and the dequeue pipe keep running.
- Channels are fully independent. A stall on one channel never blocks drain of the others.

Optional Feature:
- Macro: NPU_PORT_STATS_EN.
- Defined: adds oStallCount out (NUM_CH*16 bits).
  - Per channel, +1 each cycle oStallReq is high due to that channel.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package npu_port_pkg: op-priority encoding, FIFO entry layout (isCfg bit + DATA_W), and the DEPTH/DEQ_LAT legal-range checks.
- One natural sub-module, npu_chan_fifo: synchronous FIFO with full/empty/count, instantiated NUM_CH times via generate.

Test Plan:
- Enqueue 0xA5A5_0001 on ch1, iNpuFull=0 → oNpuDataWe[1] high for exactly 1 cycle, 2 cycles after the accept edge; slice = 0xA5A5_0001; ch0 silent.
- Cfg 0x1111, then enq 0x2222, on ch0 with iNpuFull[0] held 5 cycles → after release, CfgWe(0x1111) then DataWe(0x2222) on consecutive cycles.
- Fill ch0 with DEPTH=4 entries while full → 5th enqueue raises oStallReq. Releasing iNpuFull pops an entry and the stalled op is accepted next cycle.
- DEQ_LAT=2, dequeues ch0 then ch1 back-to-back, iNpuRdData 0xBEEF/0xCAFE → oResultValid on 2 consecutive cycles with 0xBEEF then 0xCAFE.
- iDeqOp on ch1 with iNpuEmpty[1]=1 → oStallReq=1, oNpuRe=0. Clearing empty → oNpuRe[1] pulses once.
- Assert iRst_n=0 with 3 entries queued and 1 dequeue in flight → no strobes or oResultValid afterwards; all FIFOs empty.
